pad_ring_ctrl: RTL and testbench
================================

Name: pad_ring_ctrl

Overview:
Parametrised pad-ring controller between the pulpino_top core pins and the IO pads. It generalises the static per-pad tie/OEN wiring to NUM_PADS bidirectional channels with the following features:
- per-pad input synchronisation
- programmable glitch filtering
- edge-detect pulses
- a power-on output-release sequencer that keeps every pad high-Z until a fixed number of cycles after reset.

Parameters:
NUM_PADS, 32, number of bidirectional pad channels
SYNC_STAGES, 2, synchroniser flops per input (legal 2..4)
FILT_W, 4, width of the per-pad filter counter and of filt_len_i
RELEASE_CYCLES, 16, cycles after reset deassertion during which all pads are held as inputs (0 = release on the first cycle)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
pad_in_i  in  NUM_PADS  raw pad input values (asynchronous)
pad_in_o  out  NUM_PADS  synchronised, filtered input values to the core
rise_o  out  NUM_PADS  one-cycle pulse on a 0->1 transition of pad_in_o
fall_o  out  NUM_PADS  one-cycle pulse on a 1->0 transition of pad_in_o
core_out_i  in  NUM_PADS  output data from the core
core_dir_i  in  NUM_PADS  direction from the core, 1 = drive pad
pad_out_o  out  NUM_PADS  pad output data
pad_oen_o  out  NUM_PADS  pad output enable, active-low (1 = input/high-Z)
filt_en_i  in  NUM_PADS  per-pad filter enable
filt_len_i  in  FILT_W  filter threshold in cycles, shared by all pads
pad_tie0_o  out  NUM_PADS  constant all zeros
pad_tie1_o  out  NUM_PADS  constant all ones
release_done_o  out  1  high once outputs are released; sticky until reset

Behaviour:
- Reset (rst_n=0, asynchronous) forces these values:
  - pad_oen_o = all 1s
  - pad_out_o, pad_in_o, rise_o, fall_o, release_done_o = 0
  - all synchroniser, filter and counter state = 0
- Release FSM, two states: HOLD (reset state) and RELEASED.
  - HOLD: a release counter increments each cycle. When counter == RELEASE_CYCLES-1, the FSM enters RELEASED on the next edge.
  - RELEASE_CYCLES=0: the FSM enters RELEASED on the first edge after reset.
  - RELEASED has no exit except reset. release_done_o = (state == RELEASED), driven from a register.
  - In HOLD: pad_oen_o held all 1s, pad_out_o held 0. core_* inputs are ignored.
  - In RELEASED: pad_oen_o <= ~core_dir_i and pad_out_o <= core_out_i, both registered (1-cycle latency).
  - Release takes effect on the same edge release_done_o rises: the first registered sample of core_* appears in that cycle.
- Input path, active in both states:
  - SYNC_STAGES-flop synchroniser per pad, output s.
  - One "stable" register per pad; pad_in_o = stable.
- Filter bypass (filt_en_i[k]=0 or filt_len_i=0): stable <= s every cycle. Latency from pad_in_i to pad_in_o = SYNC_STAGES+1 cycles.
- Filter active, per-pad counter cnt (FILT_W bits):
  - If s == stable: cnt <= 0.
  - Else, if cnt+1 >= filt_len_i: stable <= s and cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - Result: s must differ from stable for filt_len_i consecutive cycles before it is accepted. Latency = SYNC_STAGES+filt_len_i cycles.
  - A glitch shorter than filt_len_i cycles (after synchronisation) never reaches pad_in_o.
  - The >= compare means lowering filt_len_i mid-count takes effect immediately. The counter cannot wrap.
  - Toggling filt_en_i[k] mid-count clears that pad's cnt on the next cycle and continues in the new mode.
- Edge pulses:
  - A delayed copy stable_d <= stable (reset 0).
  - rise_o = stable & ~stable_d & release_done_o; fall_o = ~stable & stable_d & release_done_o.
  - Each pulse lasts exactly 1 cycle, aligned with the pad_in_o change.
  - Edges are suppressed in HOLD. A level that settles during HOLD produces no pulse at release.
- Reset asserted mid-operation: every output immediately returns to its reset value and the sequence restarts from HOLD.
- Ties: pad_tie0_o and pad_tie1_o are combinational constants, valid in reset too.

Test Plan:
- Release timing, RELEASE_CYCLES=16, core_dir_i=all 1s, core_out_i=0xA5A5A5A5 from reset:
  - pad_oen_o = 0xFFFFFFFF for exactly 16 cycles after rst_n rises.
  - Then, in the cycle release_done_o goes 1: pad_oen_o = 0, pad_out_o = 0xA5A5A5A5.
- Bypass latency, SYNC_STAGES=2, filt_en_i=0: raise pad_in_i[3] at cycle t -> pad_in_o[3]=1 and rise_o[3]=1 at t+3, rise_o[3]=0 at t+4.
- Glitch reject, filt_en_i[5]=1, filt_len_i=4:
  - A 3-cycle high pulse on pad_in_i[5] -> pad_in_o[5] stays 0, no rise_o.
  - A 4-cycle pulse -> pad_in_o[5]=1 at cycle t+6 (2 sync cycles + 4 filter cycles), then fall_o[5] pulses once it returns low for 4 cycles.
- Threshold change mid-count: filt_len_i=15 and input held high for 5 cycles, then filt_len_i=3 -> pad_in_o updates on the next edge.
- HOLD edge suppression: pad_in_i[0]=1 from reset -> pad_in_o[0]=1 during HOLD, rise_o[0] never asserts.
- Mid-run reset: pulse rst_n low for 1 cycle while released -> pad_oen_o = all 1s immediately, release_done_o=0, 16-cycle HOLD repeats.

Source files
------------

// File: rtl/pad_ring_ctrl.sv
// Pad-ring controller: per-pad input sync, glitch filter, edge pulses,
// and a power-on sequencer that holds every pad high-Z after reset.
module pad_ring_ctrl #(
  parameter int NUM_PADS       = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_W         = 4,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PADS-1:0] pad_in_i,
  output logic [NUM_PADS-1:0] pad_in_o,
  output logic [NUM_PADS-1:0] rise_o,
  output logic [NUM_PADS-1:0] fall_o,
  input  logic [NUM_PADS-1:0] core_out_i,
  input  logic [NUM_PADS-1:0] core_dir_i,
  output logic [NUM_PADS-1:0] pad_out_o,
  output logic [NUM_PADS-1:0] pad_oen_o,
  input  logic [NUM_PADS-1:0] filt_en_i,
  input  logic [FILT_W-1:0]   filt_len_i,
  output logic [NUM_PADS-1:0] pad_tie0_o,
  output logic [NUM_PADS-1:0] pad_tie1_o,
  output logic                release_done_o
);

  localparam int RCW =
    (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam int RC_LAST_I =
    (RELEASE_CYCLES > 0) ? RELEASE_CYCLES - 1 : 0;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RC_LAST_I);
  localparam logic [FILT_W:0] ONE = (FILT_W+1)'(1);

  typedef enum logic {HOLD, RELEASED} state_e;

  state_e              state_q, state_d;
  logic [RCW-1:0]      rcnt_q;
  logic [NUM_PADS-1:0] oen_q, oen_d;
  logic [NUM_PADS-1:0] out_q, out_d;

  logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PADS-1:0] s;
  logic [NUM_PADS-1:0] stable_q, stable_d, stable_dly_q;
  logic [FILT_W-1:0]   cnt_q [NUM_PADS];
  logic [FILT_W-1:0]   cnt_d [NUM_PADS];
  logic                filt_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      rcnt_q  <= '0;
      oen_q   <= '1;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      oen_q   <= oen_d;
      out_q   <= out_d;
      if (state_q == HOLD)
        rcnt_q <= rcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == HOLD): begin
        if (RELEASE_CYCLES == 0 || rcnt_q == RC_LAST)
          state_d = RELEASED;
      end
      default: state_d = RELEASED;
    endcase
  end

  // Outputs are loaded with the next state so release and the
  // first core sample land on the same edge.
  always_comb begin
    oen_d = '1;
    out_d = '0;
    if (state_d == RELEASED) begin
      oen_d = ~core_dir_i;
      out_d = core_out_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_in_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign filt_on = (filt_len_i != '0);

  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < NUM_PADS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (!(filt_en_i[k] && filt_on)) begin
        stable_d[k] = s[k];
        cnt_d[k]    = '0;
      end else if (s[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (({1'b0, cnt_q[k]} + ONE) >= {1'b0, filt_len_i}) begin
        stable_d[k] = s[k];
        cnt_d[k]    = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int k = 0; k < NUM_PADS; k++)
        cnt_q[k] <= '0;
    end else begin
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int k = 0; k < NUM_PADS; k++)
        cnt_q[k] <= cnt_d[k];
    end
  end

  assign release_done_o = (state_q == RELEASED);
  assign pad_in_o       = stable_q;
  assign rise_o = stable_q & ~stable_dly_q & {NUM_PADS{release_done_o}};
  assign fall_o = ~stable_q & stable_dly_q & {NUM_PADS{release_done_o}};
  assign pad_oen_o      = oen_q;
  assign pad_out_o      = out_q;
  assign pad_tie0_o     = '0;
  assign pad_tie1_o     = '1;

endmodule

// File: tb/tb_pad_ring_ctrl.sv
// Bench for pad_ring_ctrl: expected values are queued with their
// target cycle when stimulus is applied and checked on the falling edge.
module tb_pad_ring_ctrl;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  pad_in_i, pad_in_o, rise_o, fall_o;
  logic [N-1:0]  core_out_i, core_dir_i, pad_out_o, pad_oen_o;
  logic [N-1:0]  filt_en_i, pad_tie0_o, pad_tie1_o;
  logic [3:0]    filt_len_i;
  logic          release_done_o;

  pad_ring_ctrl #(
    .NUM_PADS(N), .SYNC_STAGES(2), .FILT_W(4), .RELEASE_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pad_in_i(pad_in_i), .pad_in_o(pad_in_o),
    .rise_o(rise_o), .fall_o(fall_o),
    .core_out_i(core_out_i), .core_dir_i(core_dir_i),
    .pad_out_o(pad_out_o), .pad_oen_o(pad_oen_o),
    .filt_en_i(filt_en_i), .filt_len_i(filt_len_i),
    .pad_tie0_o(pad_tie0_o), .pad_tie1_o(pad_tie1_o),
    .release_done_o(release_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    int          sel;
    logic [31:0] msk;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h exp %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] sig(int sel);
    case (sel)
      0:       return pad_in_o;
      1:       return rise_o;
      2:       return fall_o;
      3:       return pad_oen_o;
      4:       return pad_out_o;
      default: return {31'b0, release_done_o};
    endcase
  endfunction

  task automatic push(int c, string tag, int sel,
                      logic [31:0] m, logic [31:0] e);
    exp_t x;
    x.cyc = c; x.tag = tag; x.sel = sel; x.msk = m; x.exp = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, sig(sb[i].sel) & sb[i].msk, sb[i].exp & sb[i].msk);
        sb.delete(i);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_release(int t, logic [31:0] oen, logic [31:0] dat);
    for (int k = 1; k <= 15; k++) begin
      push(t + k, "hold_oen", 3, '1, '1);
      push(t + k, "hold_out", 4, '1, '0);
      push(t + k, "hold_done", 5, 32'h1, 32'h0);
    end
    push(t + 16, "rel_oen", 3, '1, oen);
    push(t + 16, "rel_out", 4, '1, dat);
    push(t + 16, "rel_done", 5, 32'h1, 32'h1);
    push(t + 2, "hold_in0_lat", 0, 32'h1, 32'h0);
    for (int k = 3; k <= 20; k++)
      push(t + k, "hold_in0", 0, 32'h1, 32'h1);
    for (int k = 1; k <= 20; k++)
      push(t + k, "hold_rise0", 1, 32'h1, 32'h0);
  endtask

  initial begin
    int t;
    rst_n      = 1'b0;
    pad_in_i   = 32'h1;
    core_dir_i = '1;
    core_out_i = 32'hA5A5A5A5;
    filt_en_i  = '0;
    filt_len_i = 4'd0;
    tick(3);
    chk("rst_oen", pad_oen_o, '1);
    chk("rst_out", pad_out_o, '0);
    chk("rst_in", pad_in_o, '0);
    chk("rst_done", {31'b0, release_done_o}, '0);
    chk("rst_rise", rise_o, '0);
    chk("tie0", pad_tie0_o, '0);
    chk("tie1", pad_tie1_o, '1);

    rst_n = 1'b1;
    push_release(cyc, 32'h0, 32'hA5A5A5A5);
    tick(22);

    t = cyc;
    pad_in_i[3] = 1'b1;
    core_out_i  = 32'h12345678;
    core_dir_i  = 32'h0000FFFF;
    push(t + 1, "core_out", 4, '1, 32'h12345678);
    push(t + 1, "core_oen", 3, '1, 32'hFFFF0000);
    push(t + 2, "byp_in_lat", 0, 32'h8, 32'h0);
    push(t + 3, "byp_in", 0, 32'h8, 32'h8);
    push(t + 3, "byp_rise", 1, 32'h8, 32'h8);
    push(t + 4, "byp_rise_end", 1, 32'h8, 32'h0);
    tick(6);
    t = cyc;
    pad_in_i[3] = 1'b0;
    push(t + 2, "byp_in_hi", 0, 32'h8, 32'h8);
    push(t + 3, "byp_in_lo", 0, 32'h8, 32'h0);
    push(t + 3, "byp_fall", 1 + 1, 32'h8, 32'h8);
    push(t + 4, "byp_fall_end", 2, 32'h8, 32'h0);
    tick(6);

    filt_en_i[5] = 1'b1;
    filt_len_i   = 4'd4;
    tick(2);
    t = cyc;
    for (int k = 1; k <= 10; k++) begin
      push(t + k, "glitch_in", 0, 32'h20, 32'h0);
      push(t + k, "glitch_rise", 1, 32'h20, 32'h0);
    end
    pad_in_i[5] = 1'b1;
    tick(3);
    pad_in_i[5] = 1'b0;
    tick(12);

    t = cyc;
    push(t + 5, "filt_in_lat", 0, 32'h20, 32'h0);
    push(t + 6, "filt_in", 0, 32'h20, 32'h20);
    push(t + 6, "filt_rise", 1, 32'h20, 32'h20);
    push(t + 7, "filt_rise_end", 1, 32'h20, 32'h0);
    push(t + 9, "filt_in_hold", 0, 32'h20, 32'h20);
    push(t + 9, "filt_nofall", 2, 32'h20, 32'h0);
    push(t + 10, "filt_in_lo", 0, 32'h20, 32'h0);
    push(t + 10, "filt_fall", 2, 32'h20, 32'h20);
    push(t + 11, "filt_fall_end", 2, 32'h20, 32'h0);
    pad_in_i[5] = 1'b1;
    tick(4);
    pad_in_i[5] = 1'b0;
    tick(14);

    filt_len_i = 4'd15;
    t = cyc;
    push(t + 6, "thr_in_wait", 0, 32'h20, 32'h0);
    push(t + 7, "thr_in", 0, 32'h20, 32'h20);
    push(t + 7, "thr_rise", 1, 32'h20, 32'h20);
    pad_in_i[5] = 1'b1;
    tick(6);
    filt_len_i = 4'd3;
    tick(4);
    pad_in_i[5] = 1'b0;
    filt_en_i    = '0;
    tick(6);

    rst_n = 1'b0;
    #1;
    chk("mid_rst_oen", pad_oen_o, '1);
    chk("mid_rst_out", pad_out_o, '0);
    chk("mid_rst_in", pad_in_o, '0);
    chk("mid_rst_done", {31'b0, release_done_o}, '0);
    tick(1);
    rst_n = 1'b1;
    push_release(cyc, 32'hFFFF0000, 32'h12345678);
    tick(22);

    if (sb.size() != 0)
      chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
